fpmul_issue_arb: RTL and testbench

FPMUL_ISSUE_ARB -- requirements
Module: fpmul_issue_arb

---
 rtl/fpmul_issue_arb_if.sv | 64 ++++++
 rtl/fpmul_issue_arb.sv | 129 ++++++++++++
 tb/tb_fpmul_issue_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fpmul_issue_arb_if.sv
// ---------------------------------------------------------------------------
// fpmul_issue_arb_if
//   Bundle of every non-clock/reset signal of fpmul_issue_arb.
//
//   Request side (one lane per requester):
//     req_valid/req_ready : per-requester handshake
//     req_a/req_b/req_rm  : operands and rounding mode
//     req_tag             : destination tag carried to the response
//     flush               : kill everything in flight and this cycle's issue
//   Multiplier side:
//     mul_en, mul_clear[1]=stage0 / [0]=stage1, mul_a, mul_b, mul_rm
//   Response side:
//     rsp_valid/rsp_ready, rsp_id, rsp_tag
//   Status:
//     busy    : any stage holds a valid operation
//     dbg_ptr : current round-robin pointer
//
//   Handshake rule for both req and rsp: a transfer happens on a rising
//   clock edge where valid and ready are both high. Valid never waits for
//   ready. Ready may look at valid, but ready never depends on ready.
//
//   Modport slave is the arbiter. Modport master is the requesters and the
//   response consumer.
// ---------------------------------------------------------------------------
interface fpmul_issue_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][31:0]      req_a;
    logic [NUM_REQ-1:0][31:0]      req_b;
    logic [NUM_REQ-1:0][2:0]       req_rm;
    logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
    logic                          flush;

    logic                          mul_en;
    logic [1:0]                    mul_clear;
    logic [31:0]                   mul_a;
    logic [31:0]                   mul_b;
    logic [2:0]                    mul_rm;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [TAG_W-1:0]              rsp_tag;

    logic                          busy;
    logic [ID_W-1:0]               dbg_ptr;

    modport slave (
        input  req_valid, req_a, req_b, req_rm, req_tag, flush, rsp_ready,
        output req_ready, mul_en, mul_clear, mul_a, mul_b, mul_rm,
        output rsp_valid, rsp_id, rsp_tag, busy, dbg_ptr
    );

    modport master (
        output req_valid, req_a, req_b, req_rm, req_tag, flush, rsp_ready,
        input  req_ready, mul_en, mul_clear, mul_a, mul_b, mul_rm,
        input  rsp_valid, rsp_id, rsp_tag, busy, dbg_ptr
    );
endinterface

// File: rtl/fpmul_issue_arb.sv
// ---------------------------------------------------------------------------
// fpmul_issue_arb
//   Round-robin issue arbiter for a two-stage pipelined FP multiplier that
//   is shared by NUM_REQ requesters. The block tracks {valid, id, tag} for
//   each multiplier stage, so every result leaves with the id of the
//   requester that issued it and that requester's tag.
//
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous, active-high reset
//     bus : fpmul_issue_arb_if.slave (request, multiplier, response and
//           status signals; see the interface header)
//
//   Pipeline: stage 0 is the operand register and stage 1 is the output
//   register. When the output is valid and not taken, both stages and their
//   metadata stall together. An advance edge without an issue loads a
//   bubble into stage 0. Flush clears both stages and takes priority over
//   stall and issue. Flush leaves the round-robin pointer where it is.
// ---------------------------------------------------------------------------
module fpmul_issue_arb #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    fpmul_issue_arb_if.slave    bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Stage metadata, mirrors the multiplier registers
    logic             v0, v1;
    logic [ID_W-1:0]  id0, id1;
    logic [TAG_W-1:0] tag0, tag1;
    logic [ID_W-1:0]  ptr;

    logic             mul_en;
    logic             gnt_found;
    logic [ID_W-1:0]  gnt_id;
    logic             transfer;
    int               idx;
    logic [ID_W-1:0]  cand;

    // Stall only when a finished result is held. Reset always advances.
    assign mul_en = rst || !(v1 && !bus.rsp_ready);

    // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
    // This depends only on req_valid and the pointer, never on req_ready.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    assign transfer = gnt_found && mul_en && !bus.flush && !rst;

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = transfer && (gnt_id == ID_W'(i));
        end
    end

    // Operands come from the granted lane. They are zero when nothing is issued.
    always_comb begin
        bus.mul_a  = '0;
        bus.mul_b  = '0;
        bus.mul_rm = '0;
        if (transfer) begin
            bus.mul_a  = bus.req_a[gnt_id];
            bus.mul_b  = bus.req_b[gnt_id];
            bus.mul_rm = bus.req_rm[gnt_id];
        end
    end

    // Reset or flush clears both stages. An advance edge without an issue
    // clears stage 0 so the multiplier carries a bubble.
    always_comb begin
        bus.mul_clear = 2'b00;
        if (rst || bus.flush) begin
            bus.mul_clear = 2'b11;
        end else if (mul_en && !transfer) begin
            bus.mul_clear = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            id0  <= '0;
            id1  <= '0;
            tag0 <= '0;
            tag1 <= '0;
            ptr  <= '0;
        end else if (bus.flush) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (mul_en) begin
            v0   <= transfer;
            id0  <= gnt_id;
            tag0 <= transfer ? bus.req_tag[gnt_id] : '0;
            v1   <= v0;
            id1  <= id0;
            tag1 <= tag0;
            if (transfer) begin
                ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    assign bus.mul_en    = mul_en;
    assign bus.rsp_valid = v1;
    assign bus.rsp_id    = id1;
    assign bus.rsp_tag   = tag1;
    assign bus.busy      = v0 | v1;
    assign bus.dbg_ptr   = ptr;
endmodule

// File: tb/tb_fpmul_issue_arb.sv
// ---------------------------------------------------------------------------
// tb_fpmul_issue_arb
//   Bench for fpmul_issue_arb with three requesters, so the round-robin
//   pointer wraps at a value that is not a power of two.
//
//   The reference model keeps a list of in-flight operations. Each entry
//   holds a count of the advance edges still needed before it reaches the
//   output. A stall freezes every count. Reset and flush empty the list.
//   The driver pushes each expected response when it issues an operation.
//   A separate monitor pops an entry and compares it whenever the DUT
//   completes a response.
// ---------------------------------------------------------------------------
module tb_fpmul_issue_arb;
    localparam int N    = 3;
    localparam int TW   = 5;
    localparam int IW   = 2;

    logic clk;
    logic rst;

    fpmul_issue_arb_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

    fpmul_issue_arb #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [IW+TW-1:0] exp_q[$];
    int               rem_q[$];
    int               m_ptr;
    int               n_tests;
    int               n_fail;
    bit               exp_v;
    logic [IW+TW-1:0] got;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- driver + model ----------------
    task automatic step(input logic [N-1:0] v, input logic rr, input logic fl,
                        input logic rs, input bit rnd);
        int             g;
        bit             found, stall, en, xfer;
        logic [N-1:0]   exp_rdy;
        logic [1:0]     exp_clr;
        @(negedge clk);
        rst           = rs;
        bus.flush     = fl;
        bus.rsp_ready = rr;
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i]   = rnd ? 32'($urandom) : 32'h4000_0000;
            bus.req_b[i]   = rnd ? 32'($urandom) : 32'h4040_0000;
            bus.req_rm[i]  = rnd ? 3'($urandom_range(0, 7)) : 3'd0;
            bus.req_tag[i] = rnd ? TW'($urandom_range(0, 31)) : TW'(5);
        end
        #1;
        found = 0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && v[(m_ptr + k) % N]) begin
                found = 1;
                g     = (m_ptr + k) % N;
            end
        end
        stall   = (rem_q.size() > 0) && (rem_q[0] == 0) && !rr;
        en      = rs || !stall;
        xfer    = found && en && !fl && !rs;
        exp_rdy = xfer ? (N'(1) << g) : '0;
        exp_clr = (rs || fl) ? 2'b11 : ((en && !xfer) ? 2'b10 : 2'b00);
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("mul_en", 64'(bus.mul_en), 64'(en));
        chk("mul_clear", 64'(bus.mul_clear), 64'(exp_clr));
        chk("mul_a", 64'(bus.mul_a), xfer ? 64'(bus.req_a[g]) : 64'd0);
        chk("mul_b", 64'(bus.mul_b), xfer ? 64'(bus.req_b[g]) : 64'd0);
        chk("mul_rm", 64'(bus.mul_rm), xfer ? 64'(bus.req_rm[g]) : 64'd0);
        chk("rr_ptr", 64'(bus.dbg_ptr), 64'(m_ptr));
        #2;
        // The monitor has already retired any response completed this cycle.
        if (rs) begin
            exp_q.delete();
            rem_q.delete();
            m_ptr = 0;
        end else if (fl) begin
            exp_q.delete();
            rem_q.delete();
        end else if (!stall) begin
            foreach (rem_q[j]) rem_q[j] = rem_q[j] - 1;
            if (xfer) begin
                exp_q.push_back({IW'(g), bus.req_tag[g]});
                rem_q.push_back(1);
                m_ptr = (g + 1) % N;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            exp_v = (rem_q.size() > 0) && (rem_q[0] == 0);
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
            chk("busy", 64'(bus.busy), 64'(rem_q.size() > 0));
            if (bus.rsp_valid && bus.rsp_ready && exp_v) begin
                got = {bus.rsp_id, bus.rsp_tag};
                chk("rsp_id_tag", 64'(got), 64'(exp_q[0]));
                void'(exp_q.pop_front());
                void'(rem_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_tests       = 0;
        n_fail        = 0;
        m_ptr         = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_rm    = '0;
        bus.req_tag   = '0;

        // reset
        for (int i = 0; i < 3; i++) step('0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1);

        // single op: 2.0 * 3.0, tag 5, from requester 0
        step(3'b001, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // contention between requesters 0 and 1
        for (int i = 0; i < 6; i++) step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // backpressure: consumer holds off for 3 cycles once results appear
        for (int i = 0; i < 2; i++) step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);

        // flush the second cycle of a two-op burst
        step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'b011, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // reset with both stages full, then all three requesters ask
        for (int i = 0; i < 2; i++) step(3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
        step(3'b111, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), 1'b1);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
